vga_timing_gen: RTL

Parametrised VGA/video timing generator and pixel output stage. It is the successor to the fixed 640x480 driver, generalised in timing, sync polarity, colour widths and client fetch latency. It issues fetch-ahead pixel coordinates to a pixel source, pipelines sync and blank to match the source latency, and drives registered RGB, HS and VS to the DAC/pins. It also provides line/frame strobes and a frame counter for animation logic.

---
 rtl/vga_timing_gen.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: fetch-ahead coordinates, latency-matched sync/blank
// pipeline and registered RGB. Optional colour-bar source is enabled by macro VGA_TESTPATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_LAT   = 1,
    parameter int R_W        = 3,
    parameter int G_W        = 3,
    parameter int B_W        = 2,
    parameter int XW         = 11,
    parameter int YW         = 10
) (
    input  logic                   CLK_PIXEL,
    input  logic                   RESET_N,
    input  logic                   ENABLE,
    input  logic                   TEST_PATTERN,
    input  logic [R_W+G_W+B_W-1:0] COLOR_DATA_IN,
    output logic [XW-1:0]          CURX,
    output logic [YW-1:0]          CURY,
    output logic                   FETCH_VALID,
    output logic                   LINE_START,
    output logic                   FRAME_START,
    output logic [15:0]            FRAME_CNT,
    output logic                   HS,
    output logic                   VS,
    output logic                   BLANK,
    output logic [R_W-1:0]         RED,
    output logic [G_W-1:0]         GREEN,
    output logic [B_W-1:0]         BLUE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = R_W + G_W + B_W;

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SS   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pipeline word: {bar[2:0] (optional), blank, hs_active, vs_active}
`ifdef VGA_TESTPATTERN_EN
    localparam int PW = 6;
`else
    localparam int PW = 3;
`endif
    localparam logic [PW-1:0] IDLE_VEC = PW'(3'b100);

    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    logic          r_hs_f;
    logic          r_vs_f;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic [PW-1:0] w_fetch_vec;
    logic [PW-1:0] w_align_vec;
    logic [CW-1:0] w_pix;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_raw = (r_h >= H_SS) && (r_h <= H_SE);
    assign w_vs_raw = (r_v >= V_SS) && (r_v <= V_SE);

    // Raster counters; held at the origin while disabled so a restart begins a fresh frame
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_h       <= {XW{1'b0}};
            r_v       <= {YW{1'b0}};
            FRAME_CNT <= 16'd0;
        end else if (!ENABLE) begin
            r_h <= {XW{1'b0}};
            r_v <= {YW{1'b0}};
        end else if (w_h_wrap) begin
            r_h <= {XW{1'b0}};
            if (w_v_wrap) begin
                r_v       <= {YW{1'b0}};
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end else begin
                r_v <= r_v + YW'(1);
            end
        end else begin
            r_h <= r_h + XW'(1);
        end
    end

    // Fetch stage: coordinates and strobes presented to the pixel source
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            CURX        <= {XW{1'b0}};
            CURY        <= {YW{1'b0}};
            FETCH_VALID <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            r_hs_f      <= 1'b0;
            r_vs_f      <= 1'b0;
        end else if (!ENABLE) begin
            CURX        <= {XW{1'b0}};
            CURY        <= {YW{1'b0}};
            FETCH_VALID <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            r_hs_f      <= 1'b0;
            r_vs_f      <= 1'b0;
        end else begin
            CURX        <= r_h;
            CURY        <= r_v;
            FETCH_VALID <= w_active;
            LINE_START  <= (r_h == {XW{1'b0}}) && (r_v < V_ACT);
            FRAME_START <= (r_h == {XW{1'b0}}) && (r_v == {YW{1'b0}});
            r_hs_f      <= w_hs_raw;
            r_vs_f      <= w_vs_raw;
        end
    end

`ifdef VGA_TESTPATTERN_EN
    localparam logic [XW+2:0] H_ACT_W = (XW+3)'(H_ACTIVE);
    logic [XW+2:0] w_bar_q;
    logic [2:0]    w_bar_idx;
    logic [2:0]    r_bar_f;

    assign w_bar_q   = {r_h, 3'b000} / H_ACT_W;
    assign w_bar_idx = (|w_bar_q[XW+2:3]) ? 3'b111 : w_bar_q[2:0];

    // Bar index registered alongside CURX so it rides the same delay as sync/blank
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bar_f <= 3'b000;
        end else if (!ENABLE) begin
            r_bar_f <= 3'b000;
        end else begin
            r_bar_f <= w_bar_idx;
        end
    end

    assign w_fetch_vec = {r_bar_f, ~FETCH_VALID, r_hs_f, r_vs_f};
`else
    logic w_unused;
    assign w_unused    = TEST_PATTERN;
    assign w_fetch_vec = {~FETCH_VALID, r_hs_f, r_vs_f};
`endif

    generate
        if (PIPE_LAT > 0) begin : g_pipe
            logic [PW-1:0] r_pipe [PIPE_LAT];

            // Delay line matching the client fetch latency
            always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        r_pipe[i] <= IDLE_VEC;
                    end
                end else begin
                    r_pipe[0] <= w_fetch_vec;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_align_vec = r_pipe[PIPE_LAT-1];
        end else begin : g_nopipe
            assign w_align_vec = w_fetch_vec;
        end
    endgenerate

    // Colour source selection for the output register
    always_comb begin
        w_pix = COLOR_DATA_IN;
`ifdef VGA_TESTPATTERN_EN
        if (TEST_PATTERN) begin
            w_pix = {{R_W{w_align_vec[5]}}, {G_W{w_align_vec[4]}}, {B_W{w_align_vec[3]}}};
        end else begin
            w_pix = COLOR_DATA_IN;
        end
`endif
    end

    // Output stage: sync at configured polarity, colour forced to zero during blanking
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            BLANK <= 1'b1;
            HS    <= ~H_SYNC_POL;
            VS    <= ~V_SYNC_POL;
            RED   <= {R_W{1'b0}};
            GREEN <= {G_W{1'b0}};
            BLUE  <= {B_W{1'b0}};
        end else begin
            BLANK <= w_align_vec[2];
            HS    <= w_align_vec[1] ? H_SYNC_POL : ~H_SYNC_POL;
            VS    <= w_align_vec[0] ? V_SYNC_POL : ~V_SYNC_POL;
            if (w_align_vec[2]) begin
                RED   <= {R_W{1'b0}};
                GREEN <= {G_W{1'b0}};
                BLUE  <= {B_W{1'b0}};
            end else begin
                RED   <= w_pix[CW-1 -: R_W];
                GREEN <= w_pix[B_W+G_W-1 -: G_W];
                BLUE  <= w_pix[B_W-1:0];
            end
        end
    end

endmodule
